fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, prefetch FIFO entries and maximum in-flight fetches (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low (reset==0 resets the block).
REQ-005 redirect_valid  input  1  branch/jal/jalr taken; restart fetch at redirect_pc.
REQ-006 redirect_pc  input  32  new fetch address.
REQ-007 imem_req  output  1  fetch request valid.
REQ-008 imem_addr  output  32  fetch byte address, word aligned.
REQ-009 imem_gnt  input  1  request accepted when imem_req && imem_gnt.
REQ-010 imem_rvalid  input  1  in-order response valid, >=1 cycle after its grant.
REQ-011 imem_rdata  input  32  response instruction word.
REQ-012 inst_valid  output  1  FIFO head valid toward decode.
REQ-013 inst_ready  input  1  decode accepts head when inst_valid && inst_ready.
REQ-014 inst_data  output  32  head instruction.
REQ-015 inst_pc  output  32  head instruction address.

Function
REQ-016 State: fetch_pc, FIFO of {pc,inst}, count, outstanding counter, discard counter.
REQ-017 imem_req=1 when count+outstanding+discard < DEPTH, no redirect_valid this cycle, not halted (REQ-031); imem_addr=fetch_pc.
REQ-018 On grant: fetch_pc += 4 (wraps mod 2^32 at 32'hFFFF_FFFC), outstanding += 1; response tagged with granted address.
REQ-019 On imem_rvalid with discard==0: push {pc,imem_rdata}, outstanding -= 1; pc tags kept in in-order tag queue of DEPTH.
REQ-020 On imem_rvalid with discard>0: drop response, discard -= 1.
REQ-021 Latency: response in cycle N -> inst_valid in cycle N+1 (registered FIFO, no bypass).
REQ-022 inst_valid = count!=0; pop on inst_valid && inst_ready; push and pop in same cycle allowed, count unchanged.
REQ-023 inst_data/inst_pc stable while inst_valid && !inst_ready.
REQ-024 Credit rule guarantees no push when full; a response with FIFO full is a protocol violation (assertion).
REQ-025 redirect_valid in cycle N: FIFO flushed (count=0, inst_valid=0 in N+1), discard += outstanding, outstanding=0, fetch_pc=redirect_pc; imem_req=0 in N; imem_req with imem_addr=redirect_pc from N+1.
REQ-026 Redirect with simultaneous imem_rvalid: that response dropped, not counted into new discard.
REQ-027 Redirect with simultaneous pop: flush wins.
REQ-028 Back-to-back redirects: last one wins; discard accumulates correctly.
REQ-029 imem_req may be withdrawn only on redirect; otherwise held with stable imem_addr until grant.

Reset
REQ-030 While reset==0 at clk edge: fetch_pc=RESET_PC, count=outstanding=discard=0, imem_req=0, inst_valid=0, inst_data=0, inst_pc=0; first request in cycle after reset==1 is sampled. Responses in flight across reset are ignored by the memory (system reset).

Configuration
REQ-031 Macro FETCH_MISALIGN_EN defined: output fetch_misalign (1 bit) added; redirect with redirect_pc[1:0]!=0 sets fetch_misalign=1 next cycle, halts requests, holds until aligned redirect or reset (reset value 0).
REQ-032 FETCH_MISALIGN_EN undefined: no fetch_misalign port; redirect_pc[1:0] ignored (treated as 2'b00), never halts.

Verification
REQ-033 Reset release, gnt=1, rvalid 1 cycle after gnt, ready=1 -> imem_addr 0,4,8,...; inst_pc 0,4,8 with inst_valid from 3rd cycle after release.
REQ-034 ready=0, DEPTH=4 -> exactly 4 grants, imem_req=0 afterwards; raising ready drains 0,4,8,C in order, fetch resumes at 0x10.
REQ-035 Two outstanding fetches (0x8,0xC), redirect to 0x100 -> both responses dropped, next inst_pc=0x100.
REQ-036 Redirect coincident with rvalid and pop -> inst_valid=0 next cycle, no stale instruction ever appears.
REQ-037 fetch_pc=32'hFFFF_FFFC granted -> next imem_addr=0x0.
REQ-038 With FETCH_MISALIGN_EN, redirect to 0x102 -> fetch_misalign=1, imem_req=0 until redirect to 0x200; without it, fetch proceeds at 0x100.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: redirect input, instruction memory req/gnt/rvalid, and decode valid/ready.
// Latency: none, wires only.
// Backpressure: carried by imem_gnt toward fetch and inst_ready toward the prefetch FIFO.
// FETCH_MISALIGN_EN adds the fetch_misalign status signal.
interface fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_EN
  logic        fetch_misalign;
`endif

  modport master (
`ifdef FETCH_MISALIGN_EN
    output fetch_misalign,
`endif
    input  redirect_valid, redirect_pc,
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
`ifdef FETCH_MISALIGN_EN
    input  fetch_misalign,
`endif
    output redirect_valid, redirect_pc,
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction prefetch: credit-limited fetch requests feeding a DEPTH-entry {pc,inst} FIFO toward decode.
// Latency: memory response in cycle N is visible on inst_valid in cycle N+1 (registered FIFO, no bypass).
// Backpressure: requests stop once FIFO entries + in-flight + to-be-discarded reach DEPTH; redirect flushes.
// Optional macro FETCH_MISALIGN_EN: misaligned redirect raises fetch_misalign and halts fetch.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [CW:0]   CREDITS = (CW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic          run;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] count, outstanding, discard;
  logic [CW-1:0] count_nxt, outstanding_nxt, discard_nxt;
  logic [AW-1:0] rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   tag_q     [DEPTH];
  logic [CW:0]   in_use;
  logic [31:0]   target;
  logic          halted;
  logic          grant, push, drop, pop;

  // Low two bits never reach fetch_pc; with the misalign feature they only set the flag.
  assign target = {bus.redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_EN
  logic misalign;

  // Sticky misaligned-target flag; only another redirect or reset can clear it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      misalign <= 1'b0;
    end else if (bus.redirect_valid) begin
      misalign <= (bus.redirect_pc[1:0] != 2'b00);
    end
  end

  assign halted             = misalign;
  assign bus.fetch_misalign = misalign;
`else
  assign halted = 1'b0;
`endif

  // Every credit is held by a FIFO entry, an in-flight fetch, or a response still to be dropped.
  assign in_use    = {1'b0, count} + {1'b0, outstanding} + {1'b0, discard};
  assign bus.imem_req  = run && (in_use < CREDITS) && !bus.redirect_valid && !halted;
  assign bus.imem_addr = fetch_pc;
  assign grant = bus.imem_req && bus.imem_gnt;

  // A redirect kills whatever response arrives with it, so nothing is pushed or popped that cycle.
  assign push = bus.imem_rvalid && (discard == '0) && !bus.redirect_valid;
  assign drop = bus.imem_rvalid && (discard != '0);
  assign pop  = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;

  assign bus.inst_valid = (count != '0);
  assign bus.inst_data  = bus.inst_valid ? fifo_inst[rd_ptr] : 32'h0;
  assign bus.inst_pc    = bus.inst_valid ? fifo_pc[rd_ptr]   : 32'h0;

  // Occupancy bookkeeping; on redirect every in-flight fetch turns into a pending discard.
  always_comb begin
    count_nxt       = count;
    outstanding_nxt = outstanding;
    discard_nxt     = discard;
    if (bus.redirect_valid) begin
      count_nxt       = '0;
      outstanding_nxt = '0;
      // The response arriving now (stale either way) retires one of the pending ones.
      discard_nxt     = discard + outstanding - (bus.imem_rvalid ? ONE : '0);
    end else begin
      if (push && !pop) begin
        count_nxt = count + ONE;
      end else if (!push && pop) begin
        count_nxt = count - ONE;
      end
      if (grant && !push) begin
        outstanding_nxt = outstanding + ONE;
      end else if (!grant && push) begin
        outstanding_nxt = outstanding - ONE;
      end
      if (drop) begin
        discard_nxt = discard - ONE;
      end
    end
  end

  // Control state: fetch pointer, counters and queue pointers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      run         <= 1'b0;
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
    end else begin
      run         <= 1'b1;
      count       <= count_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      if (bus.redirect_valid) begin
        fetch_pc <= target;
        rd_ptr   <= wr_ptr;
        tag_rd   <= tag_wr;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + 32'd4;
          tag_wr   <= tag_wr + PTR_ONE;
        end
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
          tag_rd <= tag_rd + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
      end
    end
  end

  // Storage: tag queue records granted addresses, FIFO pairs each response with its tag.
  always_ff @(posedge clk) begin
    if (grant) begin
      tag_q[tag_wr] <= fetch_pc;
    end
    if (push) begin
      fifo_pc[wr_ptr]   <= tag_q[tag_rd];
      fifo_inst[wr_ptr] <= bus.imem_rdata;
    end
  end

`ifndef SYNTHESIS
  // A response must match an earlier grant and, if kept, must find a free FIFO slot.
  rsp_has_room: assert property (@(posedge clk) disable iff (!reset)
    bus.imem_rvalid |-> ((discard != '0) || ((outstanding != '0) && (count != FULL))));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a stream-level model.
// Memory model returns mem_word(addr) in order after a random latency; decode expects sequential pcs.
module tb_fetch_unit;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  fetch_unit_if bus();

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic        tb_redir, tb_gnt, tb_ready;
  logic [31:0] tb_rpc;
  int          lat_min, lat_max, rsp_pct;

  logic [31:0] q_addr[$];
  int          q_due[$];

  logic        s_req, s_grant, s_valid, s_pop, s_rsp, s_redir;
  logic [31:0] s_addr, s_pc, s_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hC0DE_0000) + {a[15:0], a[31:16]};
  endfunction

  // One clock cycle: drive inputs after negedge, sample mid-cycle, commit memory model at posedge.
  task automatic tick();
    logic rv;
    rv = 1'b0;
    bus.redirect_valid = tb_redir;
    bus.redirect_pc    = tb_rpc;
    bus.imem_gnt       = tb_gnt;
    bus.inst_ready     = tb_ready;
    if (q_addr.size() > 0) begin
      if (q_due[0] <= cyc && int'($urandom_range(99, 0)) < rsp_pct) rv = 1'b1;
    end
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? mem_word(q_addr[0]) : 32'h0;
    #1;
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_valid = bus.inst_valid;
    s_pc    = bus.inst_pc;
    s_data  = bus.inst_data;
    s_grant = s_req && tb_gnt;
    s_pop   = s_valid && tb_ready;
    s_rsp   = rv;
    s_redir = tb_redir;
    @(posedge clk);
    if (!reset) begin
      q_addr.delete();
      q_due.delete();
    end else begin
      if (rv) begin
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      if (s_grant) begin
        q_addr.push_back(s_addr);
        q_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    tb_redir = 1'b0; tb_gnt = 1'b0; tb_ready = 1'b0; tb_rpc = 32'h0;
    rsp_pct = 100; lat_min = 1; lat_max = 1;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tb_redir = 1'b0; tb_gnt = 1'b1; tb_ready = 1'b1; tb_rpc = 32'h0;
    rsp_pct = 100; lat_min = 1; lat_max = 1;
    reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (s_req !== 1'b0 || s_valid !== 1'b0 || s_data !== 32'h0 || s_pc !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: got req=%b valid=%b data=%h pc=%h, want all zero", s_req, s_valid, s_data, s_pc);
      end
    end
    reset = 1'b1;
    tick();
    n_tests++;
    if (s_req !== 1'b0) begin
      n_fail++; $display("FAIL release_cycle_req: got %b want 0", s_req);
    end
    tick();
    n_tests++;
    if (s_req !== 1'b1 || s_addr !== 32'h0) begin
      n_fail++; $display("FAIL first_request: got req=%b addr=%h want req=1 addr=00000000", s_req, s_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    tb_gnt = 1'b1; tb_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_tests++;
      if (s_req !== 1'b1 || s_addr !== 32'(4 * k)) begin
        n_fail++; $display("FAIL stream_addr[%0d]: got req=%b addr=%h want addr=%h", k, s_req, s_addr, 32'(4 * k));
      end
      n_tests++;
      if (k < 2) begin
        if (s_valid !== 1'b0) begin
          n_fail++; $display("FAIL stream_early_valid[%0d]: got %b want 0", k, s_valid);
        end
      end else if (s_valid !== 1'b1 || s_pc !== 32'(4 * (k - 2)) || s_data !== mem_word(32'(4 * (k - 2)))) begin
        n_fail++; $display("FAIL stream_inst[%0d]: got valid=%b pc=%h data=%h want pc=%h", k, s_valid, s_pc, s_data, 32'(4 * (k - 2)));
      end
    end
  endtask

  task automatic test_backpressure();
    int g;
    int pops;
    logic got;
    logic [31:0] exp, first_g;
    do_reset();
    tb_gnt = 1'b1; tb_ready = 1'b0;
    g = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_grant) begin
        n_tests++;
        if (s_addr !== 32'(4 * g)) begin
          n_fail++; $display("FAIL bp_grant_addr[%0d]: got %h want %h", g, s_addr, 32'(4 * g));
        end
        g++;
      end
    end
    n_tests++;
    if (g != DEPTH) begin
      n_fail++; $display("FAIL bp_grant_count: got %0d want %0d", g, DEPTH);
    end
    n_tests++;
    if (s_req !== 1'b0) begin
      n_fail++; $display("FAIL bp_req_when_full: got %b want 0", s_req);
    end
    tb_ready = 1'b1;
    pops = 0; got = 1'b0; exp = 32'h0; first_g = 32'h0;
    for (int b = 0; b < 30 && (pops < 4 || !got); b++) begin
      tick();
      if (s_grant && !got) begin
        got = 1'b1; first_g = s_addr;
      end
      if (s_pop) begin
        n_tests++;
        if (s_pc !== exp || s_data !== mem_word(exp)) begin
          n_fail++; $display("FAIL bp_drain_order: got pc=%h data=%h want pc=%h", s_pc, s_data, exp);
        end
        exp += 32'd4; pops++;
      end
    end
    n_tests++;
    if (pops < 4 || !got || first_g !== 32'h10) begin
      n_fail++; $display("FAIL bp_resume: got pops=%0d grant=%b addr=%h want pops>=4 addr=00000010", pops, got, first_g);
    end
  endtask

  task automatic test_redirect();
    logic seen, first;
    logic [31:0] first_addr;
    do_reset();
    tb_gnt = 1'b1; tb_ready = 1'b1;
    seen = 1'b0;
    for (int b = 0; b < 20 && !seen; b++) begin
      tick();
      if (s_grant && s_addr == 32'h4) seen = 1'b1;
    end
    tb_gnt = 1'b0;
    tick(); tick(); tick();
    rsp_pct = 0; tb_gnt = 1'b1;
    seen = 1'b0; first = 1'b1; first_addr = 32'h0;
    for (int b = 0; b < 20 && !seen; b++) begin
      tick();
      if (s_grant && first) begin
        first = 1'b0; first_addr = s_addr;
      end
      if (s_grant && s_addr == 32'hC) seen = 1'b1;
    end
    n_tests++;
    if (!seen || first_addr !== 32'h8) begin
      n_fail++; $display("FAIL redir_setup: got seen=%b first=%h want first=00000008", seen, first_addr);
    end
    tb_gnt = 1'b0;
    tick();
    tb_redir = 1'b1; tb_rpc = 32'h100;
    tick();
    n_tests++;
    if (s_req !== 1'b0) begin
      n_fail++; $display("FAIL redir_req_same_cycle: got %b want 0", s_req);
    end
    tb_redir = 1'b0; rsp_pct = 100; tb_gnt = 1'b1;
    tick();
    n_tests++;
    if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h100) begin
      n_fail++; $display("FAIL redir_next_cycle: got valid=%b req=%b addr=%h want 0 1 00000100", s_valid, s_req, s_addr);
    end
    seen = 1'b0;
    for (int b = 0; b < 20 && !seen; b++) begin
      tick();
      if (s_pop) begin
        seen = 1'b1;
        n_tests++;
        if (s_pc !== 32'h100 || s_data !== mem_word(32'h100)) begin
          n_fail++; $display("FAIL redir_first_inst: got pc=%h data=%h want pc=00000100", s_pc, s_data);
        end
      end
    end
    if (!seen) begin
      n_tests++; n_fail++; $display("FAIL redir_timeout: got no instruction want pc=00000100");
    end
  endtask

  task automatic test_coincident();
    int pops;
    logic [31:0] exp;
    do_reset();
    tb_gnt = 1'b1; tb_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    tb_redir = 1'b1; tb_rpc = 32'h200;
    tick();
    n_tests++;
    if (s_valid !== 1'b1 || s_rsp !== 1'b1) begin
      n_fail++; $display("FAIL coinc_setup: got valid=%b rvalid=%b want 1 1", s_valid, s_rsp);
    end
    tb_redir = 1'b0;
    tick();
    n_tests++;
    if (s_valid !== 1'b0) begin
      n_fail++; $display("FAIL coinc_flush: got valid=%b want 0", s_valid);
    end
    pops = 0; exp = 32'h200;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_pop) begin
        n_tests++;
        if (s_pc !== exp || s_data !== mem_word(exp)) begin
          n_fail++; $display("FAIL coinc_stream: got pc=%h data=%h want pc=%h", s_pc, s_data, exp);
        end
        exp += 32'd4; pops++;
      end
    end
    n_tests++;
    if (pops < 5) begin
      n_fail++; $display("FAIL coinc_progress: got %0d pops want >=5", pops);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] grants[$];
    logic [31:0] exp;
    do_reset();
    tb_gnt = 1'b1; tb_ready = 1'b1;
    tb_redir = 1'b1; tb_rpc = 32'hFFFF_FFF8;
    tick();
    tb_redir = 1'b0;
    exp = 32'hFFFF_FFF8;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_grant) grants.push_back(s_addr);
      if (s_pop) begin
        n_tests++;
        if (s_pc !== exp || s_data !== mem_word(exp)) begin
          n_fail++; $display("FAIL wrap_stream: got pc=%h want %h", s_pc, exp);
        end
        exp += 32'd4;
      end
    end
    n_tests++;
    if (grants.size() < 3) begin
      n_fail++; $display("FAIL wrap_grants: got %0d grants want >=3", grants.size());
    end else if (grants[0] !== 32'hFFFF_FFF8 || grants[1] !== 32'hFFFF_FFFC || grants[2] !== 32'h0) begin
      n_fail++; $display("FAIL wrap_grants: got %h %h %h want fffffff8 fffffffc 00000000", grants[0], grants[1], grants[2]);
    end
  endtask

  task automatic test_misalign();
    logic seen;
    do_reset();
    tb_gnt = 1'b1; tb_ready = 1'b1;
    tick(); tick(); tick();
    tb_redir = 1'b1; tb_rpc = 32'h102;
    tick();
    tb_redir = 1'b0;
`ifdef FETCH_MISALIGN_EN
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if (s_req !== 1'b0 || bus.fetch_misalign !== 1'b1) begin
        n_fail++; $display("FAIL misalign_halt: got req=%b misalign=%b want 0 1", s_req, bus.fetch_misalign);
      end
    end
    tb_redir = 1'b1; tb_rpc = 32'h200;
    tick();
    tb_redir = 1'b0;
    tick();
    n_tests++;
    if (bus.fetch_misalign !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h200) begin
      n_fail++; $display("FAIL misalign_clear: got misalign=%b req=%b addr=%h want 0 1 00000200", bus.fetch_misalign, s_req, s_addr);
    end
`else
    tick();
    n_tests++;
    if (s_req !== 1'b1 || s_addr !== 32'h100) begin
      n_fail++; $display("FAIL misalign_ignored: got req=%b addr=%h want 1 00000100", s_req, s_addr);
    end
    seen = 1'b0;
    for (int b = 0; b < 20 && !seen; b++) begin
      tick();
      if (s_pop) begin
        seen = 1'b1;
        n_tests++;
        if (s_pc !== 32'h100) begin
          n_fail++; $display("FAIL misalign_first_inst: got pc=%h want 00000100", s_pc);
        end
      end
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, prev_pc, prev_data, prev_addr;
    logic        hold_v, hold_req, after_redir;
    do_reset();
    lat_min = 1; lat_max = 4;
    exp_pc = 32'h0; hold_v = 1'b0; hold_req = 1'b0; after_redir = 1'b0;
    prev_pc = 32'h0; prev_data = 32'h0; prev_addr = 32'h0;
    for (int i = 0; i < 800; i++) begin
      tb_gnt   = (int'($urandom_range(99, 0)) < 70);
      tb_ready = (int'($urandom_range(99, 0)) < 60);
      tb_redir = (int'($urandom_range(99, 0)) < 4);
      tb_rpc   = $urandom & 32'hFFFF_FFFC;
      rsp_pct  = 75;
      tick();
      if (after_redir) begin
        n_tests++;
        if (s_valid !== 1'b0) begin
          n_fail++; $display("FAIL rnd_flush[%0d]: got valid=%b want 0", i, s_valid);
        end
      end
      if (hold_v) begin
        n_tests++;
        if (s_valid !== 1'b1 || s_pc !== prev_pc || s_data !== prev_data) begin
          n_fail++; $display("FAIL rnd_hold[%0d]: got valid=%b pc=%h data=%h want pc=%h data=%h", i, s_valid, s_pc, s_data, prev_pc, prev_data);
        end
      end
      if (hold_req && !s_redir) begin
        n_tests++;
        if (s_req !== 1'b1 || s_addr !== prev_addr) begin
          n_fail++; $display("FAIL rnd_req_hold[%0d]: got req=%b addr=%h want 1 %h", i, s_req, s_addr, prev_addr);
        end
      end
      if (s_redir) begin
        n_tests++;
        if (s_req !== 1'b0) begin
          n_fail++; $display("FAIL rnd_redir_req[%0d]: got %b want 0", i, s_req);
        end
        exp_pc = tb_rpc;
      end else if (s_pop) begin
        n_tests++;
        if (s_pc !== exp_pc || s_data !== mem_word(exp_pc)) begin
          n_fail++; $display("FAIL rnd_stream[%0d]: got pc=%h data=%h want pc=%h data=%h", i, s_pc, s_data, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4;
      end
      after_redir = s_redir;
      hold_v      = s_valid && !tb_ready && !s_redir;
      prev_pc     = s_pc;
      prev_data   = s_data;
      hold_req    = s_req && !tb_gnt && !s_redir;
      prev_addr   = s_addr;
    end
    tb_redir = 1'b0;
    lat_min = 1; lat_max = 1;
  endtask

  initial begin
    reset = 1'b0;
    tb_redir = 1'b0; tb_gnt = 1'b0; tb_ready = 1'b0; tb_rpc = 32'h0;
    rsp_pct = 100; lat_min = 1; lat_max = 1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.inst_ready     = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_coincident();
    test_wrap();
    test_misalign();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
